// File: rtl/div_sequencer_pkg.sv
// rtl/div_sequencer_pkg.sv - shared state encoding and constants for the division sequencer
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  localparam int          DIV_STEPS         = 32;
  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - restoring DIV/DIVU sequencer driving an external shared subtractor
// Optional DIV_SEQUENCER_SIGNED_EN adds signed_op for signed division.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = DIV_STEPS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_SEQUENCER_SIGNED_EN
  input  logic             signed_op,
`endif
  output logic [WIDTH-1:0] sub_a,
  output logic [WIDTH-1:0] sub_b,
  input  logic [WIDTH-1:0] sub_diff,
  input  logic             sub_carry,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int            CW        = $clog2(STEPS);
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, d_q, d_d;
  logic [WIDTH-1:0] quot_q, quot_d, rem_q, rem_d;
  logic [WIDTH-1:0] sub_a_q, sub_a_d, sub_b_q, sub_b_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dz_q, dz_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic [WIDTH-1:0] a_mag, b_mag, p, r_step, q_step;
  logic             take, neg_q_acc, neg_r_acc;

`ifdef DIV_SEQUENCER_SIGNED_EN
  assign neg_r_acc = signed_op & dividend[WIDTH-1];
  assign neg_q_acc = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
  assign a_mag     = neg_r_acc ? -dividend : dividend;
  assign b_mag     = (signed_op & divisor[WIDTH-1]) ? -divisor : divisor;
`else
  assign neg_r_acc = 1'b0;
  assign neg_q_acc = 1'b0;
  assign a_mag     = dividend;
  assign b_mag     = divisor;
`endif

  // R[31] set means the shifted partial value is 33 bits wide and always exceeds D.
  assign p      = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign take   = sub_carry | r_q[WIDTH-1];
  assign r_step = take ? sub_diff : p;
  assign q_step = {q_q[WIDTH-2:0], take};

  assign sub_a     = (state_q == ST_RUN) ? p   : sub_a_q;
  assign sub_b     = (state_q == ST_RUN) ? d_q : sub_b_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign div_zero  = dz_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    count_d = count_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
    sub_a_d = sub_a_q;
    sub_b_d = sub_b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          q_d     = a_mag;
          d_d     = b_mag;
          r_d     = '0;
          count_d = '0;
          dz_d    = 1'b0;
          neg_q_d = neg_q_acc;
          neg_r_d = neg_r_acc;
          if (divisor == '0) begin
            // Results are final at acceptance; remainder is the raw dividend.
            state_d = ST_DONE;
            quot_d  = DIV_ZERO_QUOTIENT;
            rem_d   = dividend;
            dz_d    = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        r_d     = r_step;
        q_d     = q_step;
        count_d = count_q + CW'(1);
        sub_a_d = p;
        sub_b_d = d_q;
        if (count_q == LAST_STEP) begin
          state_d = ST_DONE;
          quot_d  = neg_q_q ? -q_step : q_step;
          rem_d   = neg_r_q ? -r_step : r_step;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      count_q <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
      sub_a_q <= '0;
      sub_b_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      count_q <= count_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
      sub_a_q <= sub_a_d;
      sub_b_q <= sub_b_d;
    end
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
Multi-cycle controller that sequences a shared 32-bit subtractor, whose carry-out of 1 means "no borrow" (A >= B), to perform restoring division for DIV/DIVU. It sits beside the ALU and drives the subtractor's A/B inputs each cycle. It samples the difference and carry-out, and accumulates quotient and remainder for the HI/LO write-back.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported.
- STEPS, 32, iterations per division. Must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse. Sampled only in IDLE.
- dividend  in  32  numerator. Sampled with start.
- divisor  in  32  denominator. Sampled with start.
- sub_a  out  32  subtractor minuend.
- sub_b  out  32  subtractor subtrahend.
- sub_diff  in  32  subtractor result, sub_a - sub_b mod 2^32.
- sub_carry  in  1  subtractor carry-out. 1 = no borrow.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results are valid.
- quotient  out  32  result, held until the next accepted start.
- remainder  out  32  result, held until the next accepted start.
- div_zero  out  1  set with done when divisor == 0.

Behaviour:
- Reset (async, rst_n = 0): state = IDLE.
  - busy, done, div_zero = 0.
  - quotient, remainder = 0.
  - Internal R, Q, D, count = 0.
  - sub_a, sub_b = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start = 1: latch Q = dividend, D = divisor, R = 0, count = 0, clear div_zero.
  - If divisor == 0: go to DONE.
  - Otherwise: go to RUN.
  - start = 0: stay in IDLE. busy = 0.
- RUN (busy = 1): each cycle compute P = {R[30:0], Q[31]}; drive sub_a = P, sub_b = D.
  - Take the subtract when (sub_carry | R[31]). R[31] covers the 33-bit partial value, which always exceeds D.
    - Taken: R <= sub_diff, Q <= {Q[30:0], 1}.
    - Not taken: R <= P, Q <= {Q[30:0], 0}.
  - count increments. After the step with count == STEPS-1, go to DONE.
- DONE: one cycle.
  - done = 1, busy = 0.
  - quotient/remainder registers load from Q/R.
  - Next state is always IDLE.
- Divide by zero: quotient = 32'hFFFFFFFF, remainder = dividend, div_zero = 1.
- Latency:
  - Normal: start sampled at edge 0; done high in cycle 33 (32 RUN + 1 DONE).
  - Divide by zero: done high in cycle 1.
- Back-to-back: start may be asserted while done = 1. It is ignored; it is accepted only in IDLE, i.e. the cycle after done.
- start while busy or in DONE: ignored, no side effects.
- Operand inputs are don't-care except in the cycle start is accepted.
- Reset mid-RUN: aborts immediately. No done pulse; outputs return to reset values.
- In IDLE/DONE, sub_a/sub_b hold their last values. The subtractor is free for other users, since the mux is owned by the ALU.

Optional Feature:
- Macro: DIV_SEQUENCER_SIGNED_EN.
- With the macro: adds input signed_op (1 bit, sampled with start).
  - When set, operands are converted to magnitudes at acceptance, and signs are recorded.
  - At DONE: quotient is negated if the signs differ; remainder takes the dividend's sign. Results truncate toward zero.
  - -2^31 / -1 yields quotient 32'h80000000, remainder 0.
  - Divide by zero: quotient 32'hFFFFFFFF, remainder = raw dividend, regardless of signed_op.
  - Latency is unchanged; negation is done combinationally into the output registers.
- Without the macro: no signed_op port; unsigned only.

Decomposition:
- Shared package holds:
  - state enum (IDLE, RUN, DONE) with a 2-bit encoding;
  - DIV_STEPS = 32;
  - DIV_ZERO_QUOTIENT = 32'hFFFFFFFF.
- No sub-module. The subtractor stays an external shared instance, and the step logic is small enough to stay inline.

Test Plan:
- dividend = 100, divisor = 7: done at cycle 33; quotient = 14, remainder = 2, div_zero = 0; busy high cycles 1-32.
- dividend = 32'hFFFFFFFF, divisor = 1: quotient = 32'hFFFFFFFF, remainder = 0. Also dividend = 32'hFFFFFFFF, divisor = 32'h80000000: quotient = 1, remainder = 32'h7FFFFFFF. Both exercise the R[31] path.
- divisor = 0, dividend = 55: done at cycle 1; quotient = 32'hFFFFFFFF, remainder = 55, div_zero = 1.
- start re-pulsed at cycle 10 with different operands: ignored; first result unchanged. Start the cycle after done: accepted; second result correct.
- rst_n low at cycle 15 of RUN: busy = 0, quotient = 0, no done. Then a new division 9/3: quotient = 3, remainder = 0.
- With DIV_SEQUENCER_SIGNED_EN:
  - -7 / 2 signed: quotient = -3, remainder = -1.
  - 7 / -2: quotient = -3, remainder = 1.
  - -2^31 / -1: quotient = 32'h80000000, remainder = 0.
